// File: rtl/fifo_flow_ctrl.sv
// Synchronous FIFO with threshold flags, hysteretic pause FSM and error reporting.
// Optional FIFO_ERR_STICKY_EN: Error_Fifo latches until reset instead of pulsing.
module fifo_flow_ctrl #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] Fifo_Data_in,
  input  logic [ADDR_WIDTH:0]   umbral_bajo,
  input  logic [ADDR_WIDTH:0]   umbral_alto,
  output logic [DATA_WIDTH-1:0] Fifo_Data_out,
  output logic                  Data_valid,
  output logic [ADDR_WIDTH:0]   Fifo_Count,
  output logic                  Fifo_Empty,
  output logic                  Fifo_Full,
  output logic                  Almost_Empty,
  output logic                  Almost_Full,
  output logic                  Pausa,
  output logic                  Error_Fifo
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_PAUSE = 1'b1
  } state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_nxt;
  logic [CW-1:0]         lo_c;
  logic [CW-1:0]         hi_c;
  logic                  empty_c;
  logic                  full_c;
  logic                  pop_acc_c;
  logic                  push_acc_c;
  logic                  err_c;
  state_t                state;
  state_t                state_nxt;

  // Occupancy decode and thresholds saturated at DEPTH
  assign empty_c = (count == '0);
  assign full_c  = (count == CW'(DEPTH));
  assign lo_c    = (umbral_bajo > CW'(DEPTH)) ? CW'(DEPTH) : umbral_bajo;
  assign hi_c    = (umbral_alto > CW'(DEPTH)) ? CW'(DEPTH) : umbral_alto;

  // A pop frees a slot in the same cycle, so a full FIFO can take push+pop
  assign pop_acc_c  = pop && !empty_c;
  assign push_acc_c = push && (!full_c || pop_acc_c);
  assign err_c      = (push && full_c && !pop_acc_c) || (pop && empty_c);

  always_comb begin
    count_nxt = count;
    case ({push_acc_c, pop_acc_c})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (push_acc_c) begin
      mem[wr_ptr] <= Fifo_Data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      Fifo_Data_out <= '0;
      Data_valid    <= 1'b0;
    end else begin
      count      <= count_nxt;
      Data_valid <= pop_acc_c;
      if (push_acc_c) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (pop_acc_c) begin
        rd_ptr        <= rd_ptr + ADDR_WIDTH'(1);
        Fifo_Data_out <= mem[rd_ptr];
      end
    end
  end

  // Pause FSM state register
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state <= S_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Hysteresis; the assert condition wins when thresholds overlap
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN: begin
        if (count_nxt >= hi_c) begin
          state_nxt = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (count_nxt >= hi_c) begin
          state_nxt = S_PAUSE;
        end else if (count_nxt <= lo_c) begin
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      Error_Fifo <= 1'b0;
    end else begin
`ifdef FIFO_ERR_STICKY_EN
      Error_Fifo <= Error_Fifo || err_c;
`else
      Error_Fifo <= err_c;
`endif
    end
  end

  assign Fifo_Count   = count;
  assign Fifo_Empty   = empty_c;
  assign Fifo_Full    = full_c;
  assign Almost_Empty = !empty_c && (count <= lo_c);
  assign Almost_Full  = (count >= hi_c) && !full_c;
  assign Pausa        = (state == S_PAUSE);

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Directed, table-driven bench for fifo_flow_ctrl (DATA_WIDTH=6, ADDR_WIDTH=2).
module tb_fifo_flow_ctrl;

`ifdef FIFO_ERR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  typedef struct {
    logic       push;
    logic       pop;
    logic [5:0] din;
    logic [5:0] dout;
    logic       dv;
    logic [2:0] cnt;
    logic       emp;
    logic       ful;
    logic       ae;
    logic       af;
    logic       pa;
    logic       er;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       push;
  logic       pop;
  logic [5:0] Fifo_Data_in;
  logic [2:0] umbral_bajo;
  logic [2:0] umbral_alto;
  logic [5:0] Fifo_Data_out;
  logic       Data_valid;
  logic [2:0] Fifo_Count;
  logic       Fifo_Empty;
  logic       Fifo_Full;
  logic       Almost_Empty;
  logic       Almost_Full;
  logic       Pausa;
  logic       Error_Fifo;

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  err_seen = 1'b0;
  vec_t tv [$];

  fifo_flow_ctrl #(.DATA_WIDTH(6), .ADDR_WIDTH(2)) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .push         (push),
    .pop          (pop),
    .Fifo_Data_in (Fifo_Data_in),
    .umbral_bajo  (umbral_bajo),
    .umbral_alto  (umbral_alto),
    .Fifo_Data_out(Fifo_Data_out),
    .Data_valid   (Data_valid),
    .Fifo_Count   (Fifo_Count),
    .Fifo_Empty   (Fifo_Empty),
    .Fifo_Full    (Fifo_Full),
    .Almost_Empty (Almost_Empty),
    .Almost_Full  (Almost_Full),
    .Pausa        (Pausa),
    .Error_Fifo   (Error_Fifo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected Error_Fifo given the non-sticky per-cycle error expectation
  function automatic logic exp_err(input logic e);
    err_seen = err_seen | e;
    return STICKY ? err_seen : e;
  endfunction

  task automatic check_all(input string tag, input vec_t v);
    chk({tag, " dout"}, int'(Fifo_Data_out), int'(v.dout));
    chk({tag, " dv"},   int'(Data_valid),    int'(v.dv));
    chk({tag, " cnt"},  int'(Fifo_Count),    int'(v.cnt));
    chk({tag, " emp"},  int'(Fifo_Empty),    int'(v.emp));
    chk({tag, " ful"},  int'(Fifo_Full),     int'(v.ful));
    chk({tag, " ae"},   int'(Almost_Empty),  int'(v.ae));
    chk({tag, " af"},   int'(Almost_Full),   int'(v.af));
    chk({tag, " pa"},   int'(Pausa),         int'(v.pa));
    chk({tag, " err"},  int'(Error_Fifo),    int'(exp_err(v.er)));
  endtask

  task automatic step(input logic ps, input logic pp, input logic [5:0] d);
    push = ps;
    pop = pp;
    Fifo_Data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    push = 1'b0;
    pop = 1'b0;
    Fifo_Data_in = '0;
    reset_L = 1'b0;
    err_seen = 1'b0;
    #23;
    reset_L = 1'b1;
    #1;
  endtask

  initial begin
    vec_t v;
    umbral_bajo = 3'd1;
    umbral_alto = 3'd3;
    //          push pop din     dout    dv cnt  emp ful ae af pa er
    tv.push_back('{1, 0, 6'h11, 6'h00, 0, 3'd1, 0, 0, 1, 0, 0, 0});
    tv.push_back('{1, 0, 6'h22, 6'h00, 0, 3'd2, 0, 0, 0, 0, 0, 0});
    tv.push_back('{1, 0, 6'h33, 6'h00, 0, 3'd3, 0, 0, 0, 1, 1, 0});
    tv.push_back('{1, 0, 6'h3F, 6'h00, 0, 3'd4, 0, 1, 0, 0, 1, 0});
    tv.push_back('{1, 0, 6'h05, 6'h00, 0, 3'd4, 0, 1, 0, 0, 1, 1});
    tv.push_back('{0, 0, 6'h00, 6'h00, 0, 3'd4, 0, 1, 0, 0, 1, 0});
    tv.push_back('{0, 1, 6'h00, 6'h11, 1, 3'd3, 0, 0, 0, 1, 1, 0});
    tv.push_back('{0, 1, 6'h00, 6'h22, 1, 3'd2, 0, 0, 0, 0, 1, 0});
    tv.push_back('{0, 1, 6'h00, 6'h33, 1, 3'd1, 0, 0, 1, 0, 0, 0});
    tv.push_back('{0, 1, 6'h00, 6'h3F, 1, 3'd0, 1, 0, 0, 0, 0, 0});
    tv.push_back('{1, 1, 6'h2A, 6'h3F, 0, 3'd1, 0, 0, 1, 0, 0, 1});
    tv.push_back('{0, 1, 6'h00, 6'h2A, 1, 3'd0, 1, 0, 0, 0, 0, 0});
    tv.push_back('{0, 1, 6'h00, 6'h2A, 0, 3'd0, 1, 0, 0, 0, 0, 1});
    tv.push_back('{1, 0, 6'h01, 6'h2A, 0, 3'd1, 0, 0, 1, 0, 0, 0});
    tv.push_back('{1, 0, 6'h02, 6'h2A, 0, 3'd2, 0, 0, 0, 0, 0, 0});
    tv.push_back('{1, 0, 6'h03, 6'h2A, 0, 3'd3, 0, 0, 0, 1, 1, 0});
    tv.push_back('{1, 0, 6'h04, 6'h2A, 0, 3'd4, 0, 1, 0, 0, 1, 0});
    // Full FIFO, simultaneous push/pop for 8 cycles: pointers wrap twice
    for (int i = 0; i < 8; i++) begin
      v = '{1, 1, 6'(i + 5), 6'(i + 1), 1, 3'd4, 0, 1, 0, 0, 1, 0};
      tv.push_back(v);
    end

    do_reset();
    v = '{0, 0, 6'h00, 6'h00, 0, 3'd0, 1, 0, 0, 0, 0, 0};
    check_all("reset", v);

    foreach (tv[i]) begin
      step(tv[i].push, tv[i].pop, tv[i].din);
      check_all($sformatf("vec%0d", i), tv[i]);
    end

    // Drain to count 3, then reset asynchronously in the middle of a cycle
    step(0, 1, 6'h00);
    v = '{0, 1, 6'h00, 6'h09, 1, 3'd3, 0, 0, 0, 1, 1, 0};
    check_all("drain", v);
    push = 1'b0;
    pop = 1'b0;
    #3;
    reset_L = 1'b0;
    err_seen = 1'b0;
    #1;
    v = '{0, 0, 6'h00, 6'h00, 0, 3'd0, 1, 0, 0, 0, 0, 0};
    check_all("midrst", v);
    #2;
    reset_L = 1'b1;
    step(0, 1, 6'h00);
    v = '{0, 1, 6'h00, 6'h00, 0, 3'd0, 1, 0, 0, 0, 0, 1};
    check_all("rstpop", v);
    step(1, 0, 6'h15);
    v = '{1, 0, 6'h15, 6'h00, 0, 3'd1, 0, 0, 1, 0, 0, 0};
    check_all("rstpush", v);
    step(0, 1, 6'h00);
    v = '{0, 1, 6'h00, 6'h15, 1, 3'd0, 1, 0, 0, 0, 0, 0};
    check_all("rstread", v);

    // Out-of-range high threshold saturates to DEPTH
    do_reset();
    umbral_bajo = 3'd0;
    umbral_alto = 3'd7;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 6'(i + 32));
      chk($sformatf("clamp%0d pa", i), int'(Pausa), 0);
      chk($sformatf("clamp%0d af", i), int'(Almost_Full), 0);
      chk($sformatf("clamp%0d ae", i), int'(Almost_Empty), 0);
    end
    step(1, 0, 6'h23);
    chk("clampfull pa", int'(Pausa), 1);
    chk("clampfull cnt", int'(Fifo_Count), 4);
    step(0, 1, 6'h00);
    chk("clamphold pa", int'(Pausa), 1);
    chk("clamphold dout", int'(Fifo_Data_out), 32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
